// File: rtl/axi_mst_pkg.sv
// Shared types and constants for the single-outstanding AXI4 burst master.
// Holds the controller state encoding and the AXI response codes.
// Imported by the master and by anything that decodes its status outputs.
package axi_mst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } mst_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator: command/stream client in, AW/W/B or AR/R out.
// Latency: AW/AR valid one cycle after command accept; done pulse one cycle after B or final R beat.
// Backpressure: W and R beats pass straight through (client valid/ready <-> AXI valid/ready) while bursting.
module axi_burst_master
  import axi_mst_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int ID_BASE        = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_valid,
  output logic                      rd_last,
  input  logic                      rd_ready,
  output logic                      done_valid,
  output logic                      done_write,
  output logic [1:0]                done_resp,
  output logic                      done_err,
  output logic [AXI_ID_WIDTH-1:0]   awid,
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]                awlen,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [AXI_ID_WIDTH-1:0]   bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [AXI_ID_WIDTH-1:0]   arid,
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [7:0]                arlen,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [AXI_ID_WIDTH-1:0]   rid,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  input  logic                      rlast,
  output logic                      rready
);

  localparam logic [AXI_ID_WIDTH-1:0] ID_INIT = AXI_ID_WIDTH'(ID_BASE);

  mst_state_t                state, state_nxt;
  logic [AXI_ID_WIDTH-1:0]   id_cnt;
  logic [AXI_ID_WIDTH-1:0]   id_issued;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic                      write_q;
  logic                      err_q;
  logic [1:0]                resp_q;
  logic [8:0]                beat_cnt;

  logic last_beat;
  logic accept, aw_hs, ar_hs, w_hs, b_hs, r_hs;

  assign last_beat = (beat_cnt == {1'b0, len_q});

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake strobes and all client/AXI outputs.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    aw_hs      = 1'b0;
    ar_hs      = 1'b0;
    w_hs       = 1'b0;
    b_hs       = 1'b0;
    r_hs       = 1'b0;
    cmd_ready  = 1'b0;
    awvalid    = 1'b0;
    arvalid    = 1'b0;
    wvalid     = 1'b0;
    wdata      = '0;
    wlast      = 1'b0;
    wr_ready   = 1'b0;
    bready     = 1'b0;
    rready     = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    rd_last    = 1'b0;
    done_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = rst_n;
        accept    = rst_n & cmd_valid;
        if (accept) state_nxt = cmd_write ? ST_AW : ST_AR;
      end
      ST_AW: begin
        awvalid = 1'b1;
        aw_hs   = awready;
        if (aw_hs) state_nxt = ST_W;
      end
      ST_W: begin
        wvalid   = wr_valid;
        wdata    = wr_data;
        wr_ready = wready;
        wlast    = last_beat;
        w_hs     = wr_valid & wready;
        if (w_hs && last_beat) state_nxt = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        b_hs   = bvalid;
        if (b_hs) state_nxt = ST_DONE;
      end
      ST_AR: begin
        arvalid = 1'b1;
        ar_hs   = arready;
        if (ar_hs) state_nxt = ST_R;
      end
      ST_R: begin
        rready   = rd_ready;
        rd_valid = rvalid;
        rd_data  = rdata;
        rd_last  = rlast;
        r_hs     = rvalid & rd_ready;
        // Either an early rlast or the expected final beat ends the burst.
        if (r_hs && (rlast || last_beat)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, ID allocation, beat counting and status accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_cnt    <= ID_INIT;
      id_issued <= ID_INIT;
      addr_q    <= '0;
      len_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      resp_q    <= RESP_OKAY;
      beat_cnt  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= cmd_addr;
        len_q    <= cmd_len;
        write_q  <= cmd_write;
        err_q    <= 1'b0;
        resp_q   <= RESP_OKAY;
        beat_cnt <= '0;
      end
      if (aw_hs || ar_hs) begin
        id_issued <= id_cnt;
        id_cnt    <= id_cnt + 1'b1;
      end
      if (w_hs) beat_cnt <= beat_cnt + 9'd1;
      if (b_hs) begin
        resp_q <= bresp;
        err_q  <= err_q | (bresp != RESP_OKAY) | (bid != id_issued);
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt + 9'd1;
        if (rresp > resp_q) resp_q <= rresp;
        err_q <= err_q | (rresp != RESP_OKAY) | (rid != id_issued) | (rlast != last_beat);
      end
    end
  end

  // The slave increments the address; the master only presents the start.
  assign awid       = id_cnt;
  assign arid       = id_cnt;
  assign awaddr     = addr_q;
  assign araddr     = addr_q;
  assign awlen      = len_q;
  assign arlen      = len_q;
  assign done_write = write_q;
  assign done_resp  = resp_q;
  assign done_err   = err_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomised bench for axi_burst_master with an AXI slave memory and a reference model.
// Reference memory tracks what the client wrote; the slave memory tracks what crossed W.
// Expected status comes from per-command response/fault choices made up front.
module tb_axi_burst_master;
  import axi_mst_pkg::*;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 0, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 0, rd_ready = 0;
  logic          awready = 0, wready = 0, arready = 0;
  logic [IDW-1:0] bid = '0, rid = '0;
  logic [1:0]    bresp = '0, rresp = '0;
  logic          bvalid = 0, rvalid = 0, rlast = 0;
  logic [DW-1:0] rdata = '0;
  logic          cmd_ready, wr_ready, rd_valid, rd_last, done_valid, done_write, done_err;
  logic [DW-1:0] rd_data, wdata;
  logic [1:0]    done_resp;
  logic [IDW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic          awvalid, wlast, wvalid, bready, arvalid, rready;

  axi_burst_master #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ID_BASE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_write(done_write), .done_resp(done_resp), .done_err(done_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
  );

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [DW-1:0] ref_mem [int unsigned];
  logic [DW-1:0] slv_mem [int unsigned];

  function automatic logic [63:0] dflt(int unsigned a);
    return {32'hD0D0_0000 ^ a, a * 32'h9E37};
  endfunction
  function automatic logic [63:0] ref_get(int unsigned a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction
  function automatic logic [63:0] slv_get(int unsigned a);
    if (slv_mem.exists(a)) return slv_mem[a];
    return dflt(a);
  endfunction
  function automatic logic [1:0] bad_resp();
    case ($urandom_range(0, 2))
      0:       return RESP_EXOKAY;
      1:       return RESP_SLVERR;
      default: return RESP_DECERR;
    endcase
  endfunction

  // Per-command stimulus choices.
  logic        c_write;
  logic [31:0] c_addr;
  int          c_len, b_delay, c_early, rdy_mode, exp_n;
  logic [1:0]  c_bresp;
  bit          c_bid_bad, c_rid_bad;
  logic [63:0] wbeat [256];
  logic [1:0]  rresp_l [256];
  // Per-command observations.
  bit          done_seen;
  int unsigned deadline, acc_cyc, a_first, last_hs_cyc, done_cyc;
  logic [IDW-1:0] exp_id = '0;
  logic [IDW-1:0] id_seen;
  logic        d_write, d_err, extra_done, rdy_at_done, rdy_after;
  logic [1:0]  d_resp;
  int          wbeats_seen, wdata_bad, wlast_bad, rbeats_seen, rdata_bad, rlast_bad;

  task automatic set_defaults();
    c_write = 0; c_addr = 0; c_len = 0; b_delay = 0; c_bresp = RESP_OKAY;
    c_bid_bad = 0; c_rid_bad = 0; c_early = -1; rdy_mode = 0;
    for (int i = 0; i < 256; i++) begin
      rresp_l[i] = RESP_OKAY;
      wbeat[i] = {$urandom, $urandom};
    end
  endtask

  task automatic drive_cmd();
    bit acc = 0;
    cmd_valid = 1; cmd_write = c_write; cmd_addr = c_addr; cmd_len = c_len[7:0];
    while (!acc && cyc < deadline) begin
      @(negedge clk);
      if (cmd_ready) begin acc = 1; acc_cyc = cyc; end
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    if (!acc) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic slave_wr();
    bit got = 0, fin = 0, hs;
    int i = 0;
    if (!c_write) return;
    while (!got && cyc < deadline) begin
      @(negedge clk);
      if (awvalid && a_first == 0) a_first = cyc;
      if (awvalid && awready) begin
        got = 1; id_seen = awid;
        chk("awaddr", awaddr, c_addr);
        chk("awlen", awlen, c_len);
      end
      @(posedge clk); #1;
      awready = got ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
    while (!fin && cyc < deadline) begin
      @(negedge clk);
      if (wvalid && wready) begin
        if (wdata !== wbeat[i]) wdata_bad++;
        if (wlast !== (i == c_len)) wlast_bad++;
        slv_mem[(c_addr >> 3) + i] = wdata;
        i++;
        if (wlast || i > c_len) fin = 1;
      end
      @(posedge clk); #1;
      wready = fin ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
    wbeats_seen = i;
    repeat (b_delay) @(posedge clk);
    #1;
    bvalid = 1; bresp = c_bresp; bid = c_bid_bad ? (id_seen ^ 4'd1) : id_seen;
    hs = 0;
    while (!hs && cyc < deadline) begin
      @(negedge clk);
      if (bvalid && bready) begin hs = 1; last_hs_cyc = cyc; end
      @(posedge clk); #1;
    end
    bvalid = 0;
  endtask

  task automatic client_w();
    int k = 0;
    bit hs;
    if (!c_write) return;
    while (k <= c_len && cyc < deadline && !done_seen) begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (hs) begin k++; wr_valid = 0; end
      if (k <= c_len && !wr_valid && $urandom_range(0, 3) != 0) begin
        wr_valid = 1; wr_data = wbeat[k];
      end
    end
    wr_valid = 0;
  endtask

  task automatic slave_rd();
    bit got = 0, fin = 0, hs;
    int i = 0;
    if (c_write) return;
    while (!got && cyc < deadline) begin
      @(negedge clk);
      if (arvalid && a_first == 0) a_first = cyc;
      if (arvalid && arready) begin
        got = 1; id_seen = arid;
        chk("araddr", araddr, c_addr);
        chk("arlen", arlen, c_len);
      end
      @(posedge clk); #1;
      arready = got ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
    while (!fin && cyc < deadline) begin
      if (!rvalid && $urandom_range(0, 3) != 0) begin
        rvalid = 1;
        rdata  = slv_get((c_addr >> 3) + i);
        rresp  = rresp_l[i];
        rid    = c_rid_bad ? (id_seen ^ 4'd1) : id_seen;
        rlast  = (i == c_len) || (i == c_early);
      end
      @(negedge clk);
      hs = rvalid && rready;
      if (hs) last_hs_cyc = cyc;
      @(posedge clk); #1;
      if (hs) begin
        if (rlast) fin = 1;
        rvalid = 0; rlast = 0;
        i++;
        if (i > c_len) fin = 1;
      end
    end
    rvalid = 0; rlast = 0;
  endtask

  task automatic client_r();
    int k = 0;
    bit tog = 1;
    if (c_write) return;
    while (!done_seen && cyc < deadline) begin
      rd_ready = (rdy_mode != 0) ? tog : ($urandom_range(0, 1) != 0);
      tog = ~tog;
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (rd_data !== ref_get((c_addr >> 3) + k)) rdata_bad++;
        if (rd_last !== (k == exp_n - 1)) rlast_bad++;
        k++;
      end
      @(posedge clk); #1;
    end
    rbeats_seen = k;
    rd_ready = 0;
  endtask

  task automatic watch_done();
    while (!done_seen && cyc < deadline) begin
      @(negedge clk);
      if (done_valid) begin
        done_seen = 1; done_cyc = cyc;
        d_write = done_write; d_resp = done_resp; d_err = done_err;
        rdy_at_done = cmd_ready;
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    extra_done = done_valid;
    rdy_after  = cmd_ready;
  endtask

  task automatic run_cmd(input string name);
    logic [1:0] exp_resp;
    bit exp_err;
    deadline = cyc + 3000 + b_delay;
    done_seen = 0; a_first = 0; done_cyc = 0; last_hs_cyc = 0;
    wbeats_seen = 0; wdata_bad = 0; wlast_bad = 0;
    rbeats_seen = 0; rdata_bad = 0; rlast_bad = 0;
    exp_n = (c_early >= 0) ? c_early + 1 : c_len + 1;
    if (c_write) begin
      exp_resp = c_bresp;
      exp_err  = (c_bresp != RESP_OKAY) || c_bid_bad;
    end else begin
      exp_resp = RESP_OKAY;
      for (int i = 0; i < exp_n; i++) if (rresp_l[i] > exp_resp) exp_resp = rresp_l[i];
      exp_err = (exp_resp != RESP_OKAY) || c_rid_bad || (c_early >= 0);
    end
    @(posedge clk); #1;
    fork
      drive_cmd();
      slave_wr();
      client_w();
      slave_rd();
      client_r();
      watch_done();
    join
    chk({name, ":addr_valid_lat"}, a_first, acc_cyc + 1);
    chk({name, ":id"}, id_seen, exp_id);
    exp_id = exp_id + 1'b1;
    if (c_write) begin
      chk({name, ":w_beats"}, wbeats_seen, c_len + 1);
      chk({name, ":wdata"}, wdata_bad, 0);
      chk({name, ":wlast"}, wlast_bad, 0);
      for (int i = 0; i <= c_len; i++) ref_mem[(c_addr >> 3) + i] = wbeat[i];
    end else begin
      chk({name, ":r_beats"}, rbeats_seen, exp_n);
      chk({name, ":rd_data"}, rdata_bad, 0);
      chk({name, ":rd_last"}, rlast_bad, 0);
    end
    chk({name, ":done_lat"}, done_cyc, last_hs_cyc + 1);
    chk({name, ":done_write"}, d_write, c_write);
    chk({name, ":done_resp"}, d_resp, exp_resp);
    chk({name, ":done_err"}, d_err, exp_err);
    chk({name, ":done_one_cycle"}, extra_done, 0);
    chk({name, ":ready_gap"}, {rdy_at_done, rdy_after}, 2'b01);
  endtask

  task automatic reset_mid_write();
    int n = 0;
    bit hs, saw_done = 0;
    set_defaults();
    c_write = 1; c_addr = 32'h7000; c_len = 3;
    deadline = cyc + 500;
    @(posedge clk); #1;
    awready = 1; wready = 1; wr_valid = 1; wr_data = wbeat[0];
    drive_cmd();
    while (n < 1 && cyc < deadline) begin
      @(negedge clk);
      if (done_valid) saw_done = 1;
      hs = wvalid && wready;
      @(posedge clk); #1;
      if (hs) begin n++; wr_data = wbeat[n]; end
    end
    chk("rst:beat1_seen", n, 1);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    if (done_valid) saw_done = 1;
    chk("rst:outputs_idle",
        {awvalid, wvalid, arvalid, rd_valid, done_valid, cmd_ready, wr_ready, bready, rready}, 0);
    chk("rst:awaddr", awaddr, 0);
    @(posedge clk); #1;
    rst_n = 1; wr_valid = 0; awready = 0; wready = 0;
    @(negedge clk);
    chk("rst:cmd_ready_after", cmd_ready, 1);
    repeat (3) begin
      @(negedge clk);
      if (done_valid) saw_done = 1;
    end
    chk("rst:no_done", saw_done, 0);
    exp_id = '0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    set_defaults();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:outputs",
        {awvalid, wvalid, arvalid, rd_valid, done_valid, cmd_ready, wr_ready, bready, rready}, 0);
    chk("reset:addr_len", {awaddr, araddr, awlen, arlen}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("reset:cmd_ready", cmd_ready, 1);

    set_defaults();
    c_write = 1; c_addr = 32'h100; c_len = 3; b_delay = 100;
    for (int i = 0; i < 4; i++) wbeat[i] = 64'hA0 + 64'(i);
    run_cmd("wr_0x100");

    set_defaults();
    c_addr = 32'h100; c_len = 3; rdy_mode = 1;
    run_cmd("rd_0x100");

    set_defaults();
    c_write = 1; c_addr = 32'h2000; c_len = 0;
    run_cmd("wr_len0");

    set_defaults();
    c_addr = 32'h3000; c_len = 255;
    run_cmd("rd_len255");

    set_defaults();
    c_write = 1; c_addr = 32'h180; c_len = 2; c_bresp = RESP_SLVERR;
    run_cmd("wr_slverr");

    set_defaults();
    c_addr = 32'h180; c_len = 2; c_rid_bad = 1;
    run_cmd("rd_badid");

    set_defaults();
    c_addr = 32'h100; c_len = 3; c_early = 1;
    run_cmd("rd_early_rlast");

    reset_mid_write();

    set_defaults();
    c_write = 1; c_addr = 32'h200; c_len = 5;
    run_cmd("wr_after_reset");

    for (int t = 0; t < 40; t++) begin
      set_defaults();
      c_write  = ($urandom_range(0, 1) != 0);
      c_addr   = 32'($urandom_range(0, 255)) << 3;
      c_len    = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 63) : $urandom_range(0, 15);
      b_delay  = $urandom_range(0, 4);
      rdy_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) c_bresp = bad_resp();
      c_bid_bad = ($urandom_range(0, 9) == 0);
      c_rid_bad = ($urandom_range(0, 9) == 0);
      if (c_len > 0 && $urandom_range(0, 7) == 0) c_early = $urandom_range(0, c_len - 1);
      for (int i = 0; i < 256; i++) if ($urandom_range(0, 19) == 0) rresp_l[i] = bad_resp();
      run_cmd("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
